mest_pro_run_sequencer: RTL and testbench
=========================================

// Module: mest_pro_run_sequencer
// PURPOSE
// Synthesizable run controller for the mest_pro core; replaces hand-timed bench stimulus.
// On i_go it runs 1..255 back-to-back programs. Each run sequences memory reset, core reset, a start pulse and the wait for i_all_done.
// Every valid result (result, carry, zero flag) is logged into a show-ahead FIFO, and results are counted across the campaign.
// Sits between the top-level/bench and the core's o_memory_reset/o_reset_n/o_start inputs and result outputs.
// PARAMETERS
// DATA_WIDTH      8      core result width
// MEM_RST_CYCLES  1      cycles o_memory_reset held high per run (>=1)
// CORE_RST_CYCLES 10     cycles o_core_reset_n held low after memory reset (>=1)
// START_DELAY     10     cycles between core reset release and o_start (>=0)
// LOG_DEPTH       16     result FIFO entries, power of 2 (>=2)
// TIMEOUT_CYCLES  65536  max RUN cycles without i_all_done (used only with MEST_PRO_TIMEOUT_EN)
// PORTS
// clk             in   1                      single clock, all logic on rising edge
// i_reset_n       in   1                      synchronous, active-low reset
// i_go            in   1                      pulse: start campaign (accepted only in IDLE)
// i_num_runs      in   8                      runs per campaign, sampled with i_go
// o_memory_reset  out  1                      to core memory reset
// o_core_reset_n  out  1                      to core reset_n
// o_start         out  1                      one-cycle start pulse to core
// i_result        in   DATA_WIDTH             core result
// i_valid_result  in   1                      core result valid
// i_carry         in   1                      core carry flag
// i_zero_flag     in   1                      core zero flag
// i_all_done      in   1                      core program finished
// i_log_rd        in   1                      pop FIFO head
// o_log_data      out  DATA_WIDTH+2           FIFO head {zero,carry,result}, valid when !o_log_empty
// o_log_empty     out  1                      FIFO empty
// o_log_count     out  $clog2(LOG_DEPTH)+1    FIFO occupancy
// o_overflow      out  1                      sticky: a result was dropped (FIFO full)
// o_result_count  out  16                     results seen this campaign, saturates at 16'hFFFF
// o_runs_done     out  8                      completed runs this campaign
// o_busy          out  1                      high in every state except IDLE
// o_done          out  1                      one-cycle pulse at campaign end (normal or abort)
// o_timeout       out  1                      sticky: campaign aborted by timeout
// BEHAVIOUR
// - Reset (sync, i_reset_n=0): state IDLE; o_memory_reset=0, o_core_reset_n=0, o_start=0, o_done=0, o_busy=0.
//   Reset also clears FIFO (empty=1, count=0), o_overflow, o_timeout, o_result_count, o_runs_done; applies mid-run too.
// - FSM: IDLE->MEM_RST->CORE_RST->START_WAIT->START->RUN->(MEM_RST | DONE)->IDLE; TIMEOUT state only with macro.
// - IDLE: o_core_reset_n=0. Accept i_go only if i_num_runs!=0: latch runs, clear counts/flags/FIFO, go MEM_RST.
//   i_go with i_num_runs=0, or any i_go while busy: ignored.
// - MEM_RST: o_memory_reset=1, o_core_reset_n=0 for exactly MEM_RST_CYCLES cycles.
// - CORE_RST: o_memory_reset=0, o_core_reset_n=0 for exactly CORE_RST_CYCLES cycles.
// - START_WAIT: o_core_reset_n=1 for START_DELAY cycles; START_DELAY=0 skips the state.
// - START: o_start=1 for exactly one cycle; then RUN.
// - RUN: o_core_reset_n=1; on i_all_done, o_runs_done+1 in the same edge. If it equals the latched runs -> DONE, else -> MEM_RST.
//   i_all_done outside RUN is ignored.
// - DONE: o_done=1 one cycle; next IDLE. The FIFO is preserved for readout after the campaign.
// - Logging: i_valid_result is sampled only in RUN (including the i_all_done cycle). Write {i_zero_flag,i_carry,i_result}.
//   Every valid result in RUN increments o_result_count, whether or not FIFO is full.
// - FIFO full + write w/o read: entry dropped, o_overflow<=1. Full + read + write same cycle: both occur, no overflow.
//   Empty + read: ignored. Pointers wrap modulo LOG_DEPTH. The read port is show-ahead: o_log_data changes the cycle after a pop.
// CONFIGURATION
// MEST_PRO_TIMEOUT_EN defined: RUN has a cycle counter cleared on entering RUN.
//   Reaching TIMEOUT_CYCLES without i_all_done -> TIMEOUT: o_core_reset_n=0, o_timeout<=1, o_done=1 for one cycle, then IDLE.
//   o_runs_done is not incremented on timeout.
// Not defined: RUN waits indefinitely; no counter logic; o_timeout tied 0 (port kept).
// STRUCTURE
// mest_pro_pkg: run_state_e enum and log_entry_t struct {zero,carry,result}.
// mest_pro_pkg also holds the LOG_W localparam function.
// Sub-module mest_pro_result_fifo: parametrised show-ahead sync FIFO with count/overflow; sequencer owns the FSM and counters.
// TESTING
// 1 Reset: i_reset_n=0 any state -> next edge all outputs at reset values, o_log_empty=1, o_log_count=0.
// 2 Single run, defaults: i_go, i_num_runs=1 -> o_memory_reset=1 for 1 cycle, core reset 10 cycles, 10 wait cycles, o_start 1 cycle.
//   The core then returns 3 results and i_all_done -> o_log_count=3, o_result_count=3, o_runs_done=1, o_done pulse.
// 3 Multi-run: i_num_runs=3, 2 results/run -> three start pulses, o_runs_done=3, o_result_count=6, one o_done.
// 4 FIFO: LOG_DEPTH=4, 6 results, no reads -> count=4, o_overflow=1, o_result_count=6.
//   Separately, full + simultaneous rd/wr -> count stays 4, o_overflow=0.
// 5 Ignored inputs: i_go with i_num_runs=0 -> stays IDLE; i_go during RUN -> no effect.
//   i_valid_result=1 during CORE_RST -> not logged or counted.
// 6 MEST_PRO_TIMEOUT_EN, TIMEOUT_CYCLES=100, no i_all_done -> after 100 RUN cycles: o_timeout=1, o_done pulse, IDLE, o_runs_done=0.

Source files
------------

// File: rtl/mest_pro_pkg.sv
// Shared types for the mest_pro run sequencer: FSM states, log entry layout
// and the log-entry width helper.
package mest_pro_pkg;

    localparam int LOG_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_RST,
        S_CORE_RST,
        S_START_WAIT,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } run_state_e;

    typedef struct packed {
        logic                  zero;
        logic                  carry;
        logic [LOG_DATA_W-1:0] result;
    } log_entry_t;

    function automatic int log_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/mest_pro_result_fifo.sv
// Show-ahead synchronous result FIFO with occupancy count and sticky
// overflow; i_clr empties it at campaign start.
module mest_pro_result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_overflow;

    logic w_full;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    assign w_full = (r_count == FULL);
    assign w_rd   = i_rd && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr   = i_wr && (!w_full || w_rd);
    assign w_drop = i_wr && w_full && !w_rd;

    always_ff @(posedge clk) begin
        if (!i_reset_n || i_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_rd)
                r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr)
                r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata    = r_mem[r_rptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/mest_pro_run_sequencer.sv
// Run controller for the mest_pro core: sequences memory/core reset, start
// and completion for 1..255 runs. MEST_PRO_TIMEOUT_EN adds a RUN watchdog.
module mest_pro_run_sequencer
    import mest_pro_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int MEM_RST_CYCLES  = 1,
    parameter int CORE_RST_CYCLES = 10,
    parameter int START_DELAY     = 10,
    parameter int LOG_DEPTH       = 16,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                         clk,
    input  logic                         i_reset_n,
    input  logic                         i_go,
    input  logic [7:0]                   i_num_runs,
    output logic                         o_memory_reset,
    output logic                         o_core_reset_n,
    output logic                         o_start,
    input  logic [DATA_WIDTH-1:0]        i_result,
    input  logic                         i_valid_result,
    input  logic                         i_carry,
    input  logic                         i_zero_flag,
    input  logic                         i_all_done,
    input  logic                         i_log_rd,
    output logic [DATA_WIDTH+1:0]        o_log_data,
    output logic                         o_log_empty,
    output logic [$clog2(LOG_DEPTH):0]   o_log_count,
    output logic                         o_overflow,
    output logic [15:0]                  o_result_count,
    output logic [7:0]                   o_runs_done,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_timeout
);

    localparam int LW = log_w(DATA_WIDTH);
    localparam logic [15:0] MEM_LAST  = 16'(MEM_RST_CYCLES - 1);
    localparam logic [15:0] CORE_LAST = 16'(CORE_RST_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(START_DELAY - 1);

    run_state_e  r_state;
    run_state_e  w_state_nxt;
    logic [15:0] r_cnt;
    logic [7:0]  r_runs;
    logic [7:0]  r_runs_done;
    logic [15:0] r_result_count;

    logic          w_cnt_inc;
    logic          w_accept;
    logic          w_run_end;
    logic          w_to_hit;
    logic          w_log_wr;
    logic [7:0]    w_runs_inc;
    logic [LW-1:0] w_wdata;

    assign w_runs_inc = r_runs_done + 8'd1;
    assign w_log_wr   = (r_state == S_RUN) && i_valid_result;
    assign w_wdata    = {i_zero_flag, i_carry, i_result};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_inc      = 1'b0;
        w_accept       = 1'b0;
        w_run_end      = 1'b0;
        o_memory_reset = 1'b0;
        o_core_reset_n = 1'b0;
        o_start        = 1'b0;
        o_done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_go && i_num_runs != 8'd0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MEM_RST;
                end
            end
            S_MEM_RST: begin
                o_memory_reset = 1'b1;
                if (r_cnt == MEM_LAST) w_state_nxt = S_CORE_RST;
                else w_cnt_inc = 1'b1;
            end
            S_CORE_RST: begin
                if (r_cnt == CORE_LAST)
                    w_state_nxt = (START_DELAY == 0) ? S_START : S_START_WAIT;
                else
                    w_cnt_inc = 1'b1;
            end
            S_START_WAIT: begin
                o_core_reset_n = 1'b1;
                if (r_cnt == WAIT_LAST) w_state_nxt = S_START;
                else w_cnt_inc = 1'b1;
            end
            S_START: begin
                o_core_reset_n = 1'b1;
                o_start        = 1'b1;
                w_state_nxt    = S_RUN;
            end
            S_RUN: begin
                o_core_reset_n = 1'b1;
                if (i_all_done) begin
                    w_run_end   = 1'b1;
                    w_state_nxt = (w_runs_inc == r_runs) ? S_DONE : S_MEM_RST;
                end else if (w_to_hit) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_TIMEOUT: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_runs         <= '0;
            r_runs_done    <= '0;
            r_result_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;
            if (w_accept) begin
                r_runs         <= i_num_runs;
                r_runs_done    <= '0;
                r_result_count <= '0;
            end else begin
                if (w_run_end) r_runs_done <= w_runs_inc;
                // Counts every valid result, even those the full log drops.
                if (w_log_wr && r_result_count != 16'hFFFF)
                    r_result_count <= r_result_count + 16'd1;
            end
        end
    end

`ifdef MEST_PRO_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_to_cnt;
    logic        r_timeout;

    assign w_to_hit = (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!i_reset_n || r_state != S_RUN) r_to_cnt <= '0;
        else r_to_cnt <= r_to_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n || w_accept) r_timeout <= 1'b0;
        else if (r_state == S_RUN && w_state_nxt == S_TIMEOUT) r_timeout <= 1'b1;
    end

    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    mest_pro_result_fifo #(
        .WIDTH (LW),
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_clr      (w_accept),
        .i_wr       (w_log_wr),
        .i_wdata    (w_wdata),
        .i_rd       (i_log_rd),
        .o_rdata    (o_log_data),
        .o_empty    (o_log_empty),
        .o_count    (o_log_count),
        .o_overflow (o_overflow)
    );

    assign o_busy         = (r_state != S_IDLE);
    assign o_result_count = r_result_count;
    assign o_runs_done    = r_runs_done;

endmodule

// File: tb/tb_mest_pro_run_sequencer.sv
// Directed bench for mest_pro_run_sequencer (LOG_DEPTH=4, TIMEOUT_CYCLES=100);
// the timeout scenario runs only when MEST_PRO_TIMEOUT_EN is defined.
module tb_mest_pro_run_sequencer;
    import mest_pro_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_go = 1'b0;
    logic [7:0]  i_num_runs = 8'd0;
    logic        o_memory_reset;
    logic        o_core_reset_n;
    logic        o_start;
    logic [7:0]  i_result = 8'd0;
    logic        i_valid_result = 1'b0;
    logic        i_carry = 1'b0;
    logic        i_zero_flag = 1'b0;
    logic        i_all_done = 1'b0;
    logic        i_log_rd = 1'b0;
    logic [9:0]  o_log_data;
    logic        o_log_empty;
    logic [2:0]  o_log_count;
    logic        o_overflow;
    logic [15:0] o_result_count;
    logic [7:0]  o_runs_done;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;

    int errs = 0;
    int checks = 0;
    int n_start = 0;
    int n_done = 0;

    mest_pro_run_sequencer #(
        .DATA_WIDTH     (8),
        .LOG_DEPTH      (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk            (clk),
        .i_reset_n      (i_reset_n),
        .i_go           (i_go),
        .i_num_runs     (i_num_runs),
        .o_memory_reset (o_memory_reset),
        .o_core_reset_n (o_core_reset_n),
        .o_start        (o_start),
        .i_result       (i_result),
        .i_valid_result (i_valid_result),
        .i_carry        (i_carry),
        .i_zero_flag    (i_zero_flag),
        .i_all_done     (i_all_done),
        .i_log_rd       (i_log_rd),
        .o_log_data     (o_log_data),
        .o_log_empty    (o_log_empty),
        .o_log_count    (o_log_count),
        .o_overflow     (o_overflow),
        .o_result_count (o_result_count),
        .o_runs_done    (o_runs_done),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_start) n_start++;
        if (o_done) n_done++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go(input logic [7:0] n);
        i_num_runs = n;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
    endtask

    // Leaves the bench at the negedge where o_start is high.
    task automatic wait_start(input logic noise);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_start) begin
                ok = 1'b1;
                break;
            end
            i_valid_result = noise;
            tick();
        end
        i_valid_result = 1'b0;
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL wait_start: o_start not seen within 200 cycles");
        end
    endtask

    // Entry i: result 8'h11*(i+1), carry i[0], zero (i==1).
    task automatic core_run(input int k, input logic rd_last);
        tick();
        for (int i = 0; i < k; i++) begin
            i_valid_result = 1'b1;
            i_result = 8'(8'h11 * (i + 1));
            i_carry = 1'(i % 2);
            i_zero_flag = (i == 1);
            i_log_rd = rd_last && (i == k - 1);
            tick();
        end
        i_valid_result = 1'b0;
        i_log_rd = 1'b0;
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (o_memory_reset !== 1'b0 || o_core_reset_n !== 1'b0 ||
            o_start !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_ctrl: got mr=%b crn=%b st=%b dn=%b bz=%b want 0 0 0 0 0",
                     o_memory_reset, o_core_reset_n, o_start, o_done, o_busy);
        end
        checks++;
        if (o_log_empty !== 1'b1 || o_log_count !== 3'd0) begin
            errs++;
            $display("FAIL rst_fifo: got empty=%b count=%0d want 1 0",
                     o_log_empty, o_log_count);
        end
        checks++;
        if (o_overflow !== 1'b0 || o_timeout !== 1'b0 ||
            o_result_count !== 16'd0 || o_runs_done !== 8'd0) begin
            errs++;
            $display("FAIL rst_stat: got ov=%b to=%b rc=%0d rd=%0d want 0 0 0 0",
                     o_overflow, o_timeout, o_result_count, o_runs_done);
        end
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_run();
        int mem_c = 0;
        int crst_c = 0;
        int wait_c = 0;
        int s0 = n_start;
        go(8'd1);
        for (int i = 0; i < 200; i++) begin
            if (o_start) break;
            if (o_memory_reset) mem_c++;
            else if (!o_core_reset_n) crst_c++;
            else wait_c++;
            tick();
        end
        checks++;
        if (mem_c != 1 || crst_c != 10 || wait_c != 10) begin
            errs++;
            $display("FAIL single_timing: got mem=%0d crst=%0d wait=%0d want 1 10 10",
                     mem_c, crst_c, wait_c);
        end
        core_run(3, 1'b0);
        checks++;
        if (o_done !== 1'b1 || o_runs_done !== 8'd1) begin
            errs++;
            $display("FAIL single_done: got done=%b runs=%0d want 1 1",
                     o_done, o_runs_done);
        end
        checks++;
        if (o_log_count !== 3'd3 || o_result_count !== 16'd3) begin
            errs++;
            $display("FAIL single_counts: got log=%0d res=%0d want 3 3",
                     o_log_count, o_result_count);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || n_start - s0 != 1) begin
            errs++;
            $display("FAIL single_end: got done=%b busy=%b starts=%0d want 0 0 1",
                     o_done, o_busy, n_start - s0);
        end
        checks++;
        if (o_log_data !== 10'h011) begin
            errs++;
            $display("FAIL single_head0: got %h want 011", o_log_data);
        end
        i_log_rd = 1'b1;
        tick();
        i_log_rd = 1'b0;
        checks++;
        if (o_log_data !== 10'h322 || o_log_count !== 3'd2) begin
            errs++;
            $display("FAIL single_head1: got %h cnt=%0d want 322 2",
                     o_log_data, o_log_count);
        end
    endtask

    task automatic test_multi_run();
        int s0 = n_start;
        int d0 = n_done;
        go(8'd3);
        for (int r = 0; r < 3; r++) begin
            wait_start(1'b0);
            core_run(2, 1'b0);
        end
        tick();
        tick();
        checks++;
        if (n_start - s0 != 3 || n_done - d0 != 1) begin
            errs++;
            $display("FAIL multi_pulses: got starts=%0d dones=%0d want 3 1",
                     n_start - s0, n_done - d0);
        end
        checks++;
        if (o_runs_done !== 8'd3 || o_result_count !== 16'd6) begin
            errs++;
            $display("FAIL multi_counts: got runs=%0d res=%0d want 3 6",
                     o_runs_done, o_result_count);
        end
    endtask

    task automatic test_fifo();
        go(8'd1);
        wait_start(1'b0);
        core_run(6, 1'b0);
        checks++;
        if (o_log_count !== 3'd4 || o_overflow !== 1'b1 ||
            o_result_count !== 16'd6) begin
            errs++;
            $display("FAIL fifo_ovf: got cnt=%0d ov=%b res=%0d want 4 1 6",
                     o_log_count, o_overflow, o_result_count);
        end
        checks++;
        if (o_log_data !== 10'h011) begin
            errs++;
            $display("FAIL fifo_ovf_head: got %h want 011", o_log_data);
        end
        tick();
        go(8'd1);
        wait_start(1'b0);
        core_run(5, 1'b1);
        checks++;
        if (o_log_count !== 3'd4 || o_overflow !== 1'b0) begin
            errs++;
            $display("FAIL fifo_rdwr: got cnt=%0d ov=%b want 4 0",
                     o_log_count, o_overflow);
        end
        checks++;
        if (o_log_data !== 10'h322) begin
            errs++;
            $display("FAIL fifo_rdwr_head: got %h want 322", o_log_data);
        end
        tick();
    endtask

    task automatic test_ignored();
        go(8'd0);
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_memory_reset !== 1'b0) begin
            errs++;
            $display("FAIL ign_zero_runs: got busy=%b mr=%b want 0 0",
                     o_busy, o_memory_reset);
        end
        go(8'd1);
        wait_start(1'b0);
        tick();
        i_num_runs = 8'd5;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_runs_done !== 8'd1) begin
            errs++;
            $display("FAIL ign_go_busy: got done=%b runs=%0d want 1 1",
                     o_done, o_runs_done);
        end
        tick();
        go(8'd1);
        wait_start(1'b1);
        core_run(0, 1'b0);
        checks++;
        if (o_result_count !== 16'd0 || o_log_count !== 3'd0 ||
            o_done !== 1'b1) begin
            errs++;
            $display("FAIL ign_valid: got res=%0d cnt=%0d done=%b want 0 0 1",
                     o_result_count, o_log_count, o_done);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        go(8'd1);
        wait_start(1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            i_valid_result = 1'b1;
            i_result = 8'(i);
            tick();
        end
        i_valid_result = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre: got ov=%b busy=%b want 1 1",
                     o_overflow, o_busy);
        end
        i_reset_n = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_core_reset_n !== 1'b0 ||
            o_log_empty !== 1'b1 || o_log_count !== 3'd0) begin
            errs++;
            $display("FAIL mid_rst: got busy=%b crn=%b empty=%b cnt=%0d want 0 0 1 0",
                     o_busy, o_core_reset_n, o_log_empty, o_log_count);
        end
        checks++;
        if (o_overflow !== 1'b0 || o_result_count !== 16'd0 ||
            o_runs_done !== 8'd0) begin
            errs++;
            $display("FAIL mid_rst_stat: got ov=%b res=%0d runs=%0d want 0 0 0",
                     o_overflow, o_result_count, o_runs_done);
        end
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
`ifdef MEST_PRO_TIMEOUT_EN
        int n = 0;
        go(8'd1);
        wait_start(1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (o_done) break;
            n++;
        end
        checks++;
        if (n != 100 || o_timeout !== 1'b1 || o_core_reset_n !== 1'b0) begin
            errs++;
            $display("FAIL timeout: got run_cycles=%0d to=%b crn=%b want 100 1 0",
                     n, o_timeout, o_core_reset_n);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_runs_done !== 8'd0 || o_timeout !== 1'b1) begin
            errs++;
            $display("FAIL timeout_end: got busy=%b runs=%0d to=%b want 0 0 1",
                     o_busy, o_runs_done, o_timeout);
        end
`else
        go(8'd1);
        wait_start(1'b0);
        repeat (150) tick();
        checks++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            errs++;
            $display("FAIL no_timeout: got to=%b busy=%b want 0 1",
                     o_timeout, o_busy);
        end
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_multi_run();
        test_fifo();
        test_ignored();
        test_reset_mid_run();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
